gcl_gate_sched: RTL

// - Per-port 802.1Qbv gate scheduler. Consumes the GCL load strobes issued by the register block and the synced PTP time.
// - Holds a DEPTH-entry gate control list and steps through it on elapsed PTP nanoseconds.
// - Drives the per-queue gate state to the egress arbiter.
// - Exports the list contents for register readback. One instance per switch port.

---
 rtl/gcl_gate_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gcl_gate_sched.sv
// Per-port 802.1Qbv gate scheduler: holds a gate control list, steps through it on elapsed
// PTP nanoseconds and drives the per-queue gate open mask to the egress arbiter.
// Optional feature macro: GCL_PPS_ALIGN_EN (start/resync waits for the ns-field rollover).
module gcl_gate_sched #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_STEP_NS = 1000,
  parameter int unsigned NS_WRAP     = 1_000_000_000,
  localparam int unsigned IdxW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gcl_en,
  input  logic                gcl_ld,
  input  logic [IdxW-1:0]     gcl_id,
  input  logic [8:0]          gcl_ld_data,
  input  logic                gcl_time_ld,
  input  logic [IdxW-1:0]     gcl_time_id,
  input  logic [19:0]         gcl_ld_time,
  input  logic [31:0]         sync_time_ptp_ns,
  output logic [7:0]          gate_state,
  output logic [IdxW-1:0]     gcl_ptr,
  output logic                cycle_start,
  output logic [DEPTH*9-1:0]  gcl_data_out
);

`ifdef GCL_PPS_ALIGN_EN
  typedef enum logic [1:0] {StIdle, StStart, StRun, StWaitAlign} state_e;
  localparam state_e StResync = StWaitAlign;
`else
  typedef enum logic [1:0] {StIdle, StStart, StRun} state_e;
  localparam state_e StResync = StStart;
`endif

  state_e          state_q, state_d;
  logic [8:0]      entry_q [DEPTH];
  logic [19:0]     intv_q  [DEPTH];
  logic [31:0]     prev_ns_q;
  logic [20:0]     elapsed_q, elapsed_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [7:0]      gate_q, gate_d;
  logic            cs_q, cs_d;

  logic [31:0]     delta;
  logic [20:0]     acc;
  logic [IdxW-1:0] nxt_ptr;
  logic            step_big;

  // Table storage; writes land on the edge that samples the strobe and are always accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= 9'h0FF;
        intv_q[i]  <= '0;
      end
    end else begin
      if (gcl_ld)      entry_q[gcl_id]     <= gcl_ld_data;
      if (gcl_time_ld) intv_q[gcl_time_id] <= gcl_ld_time;
    end
  end

  // Elapsed-time arithmetic: wrap-aware delta, accumulator and successor entry.
  always_comb begin
    if (sync_time_ptp_ns >= prev_ns_q) delta = sync_time_ptp_ns - prev_ns_q;
    else                               delta = sync_time_ptp_ns + NS_WRAP - prev_ns_q;
    step_big = delta > MAX_STEP_NS;
    // Safe to truncate: acc is only used when delta <= MAX_STEP_NS.
    acc      = elapsed_q + delta[20:0];
    nxt_ptr  = (entry_q[ptr_q][8] || ptr_q == IdxW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    ptr_d     = ptr_q;
    elapsed_d = elapsed_q;
    cs_d      = 1'b0;
    if (!gcl_en) begin
      state_d   = StIdle;
      gate_d    = 8'hFF;
      ptr_d     = '0;
      elapsed_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          gate_d    = 8'hFF;
          ptr_d     = '0;
          elapsed_d = '0;
          state_d   = StResync;
        end
`ifdef GCL_PPS_ALIGN_EN
        StWaitAlign: begin
          gate_d    = 8'hFF;
          ptr_d     = '0;
          elapsed_d = '0;
          if (sync_time_ptp_ns < prev_ns_q) state_d = StStart;
        end
`endif
        StStart: begin
          ptr_d     = '0;
          elapsed_d = '0;
          gate_d    = entry_q[0][7:0];
          cs_d      = 1'b1;
          state_d   = StRun;
        end
        StRun: begin
          if (step_big) begin
            state_d = StResync;
          end else if (acc < {1'b0, intv_q[ptr_q]}) begin
            elapsed_d = acc;
          end else begin
            // Residual carries into the next entry; at most one advance per clock.
            elapsed_d = acc - {1'b0, intv_q[ptr_q]};
            ptr_d     = nxt_ptr;
            gate_d    = entry_q[nxt_ptr][7:0];
            cs_d      = (nxt_ptr == '0);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Scheduler state, previous PTP sample and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      prev_ns_q <= '0;
      elapsed_q <= '0;
      ptr_q     <= '0;
      gate_q    <= 8'hFF;
      cs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_ns_q <= sync_time_ptp_ns;
      elapsed_q <= elapsed_d;
      ptr_q     <= ptr_d;
      gate_q    <= gate_d;
      cs_q      <= cs_d;
    end
  end

  // Flatten the list for register readback, entry 0 in the low bits.
  always_comb begin
    gcl_data_out = '0;
    for (int i = 0; i < DEPTH; i++) gcl_data_out[i*9 +: 9] = entry_q[i];
  end

  assign gate_state  = gate_q;
  assign gcl_ptr     = ptr_q;
  assign cycle_start = cs_q;

endmodule
